// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters and zero-latency lookup.
// Optional performance counters are built only when BTB_PERF_EN is defined.
module branch_target_buffer #(
  parameter int         ENTRIES   = 64,
  parameter logic [1:0] ALLOC_CTR = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  input  logic        lookup_en,
  output logic        btb_hit,
  output logic [31:0] btb_pc,
  output logic        predict_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic        upd_mispredict,
  input  logic        flush,
  output logic [31:0] perf_lookups,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_mispred
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic             w_valid  [ENTRIES];
  logic [TAG_W-1:0] w_tag    [ENTRIES];
  logic [31:0]      w_target [ENTRIES];
  logic [1:0]       w_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  logic [1:0]       w_up_ctr_next;
  logic             w_unused;

  assign w_lk_idx = lookup_pc[IDX_W+1:2];
  assign w_lk_tag = lookup_pc[31:IDX_W+2];
  assign w_up_idx = upd_pc[IDX_W+1:2];
  assign w_up_tag = upd_pc[31:IDX_W+2];

  // Lookup reads only registered state, so a same-cycle update is never bypassed.
  assign btb_hit       = w_valid[w_lk_idx] && (w_tag[w_lk_idx] == w_lk_tag);
  assign btb_pc        = btb_hit ? w_target[w_lk_idx] : 32'h0;
  assign predict_taken = btb_hit && w_ctr[w_lk_idx][1];

  assign w_up_hit = w_valid[w_up_idx] && (w_tag[w_up_idx] == w_up_tag);

  always_comb begin
    w_up_ctr_next = w_ctr[w_up_idx];
    if (upd_taken) begin
      if (w_ctr[w_up_idx] != 2'b11) w_up_ctr_next = w_ctr[w_up_idx] + 2'b01;
    end else begin
      if (w_ctr[w_up_idx] != 2'b00) w_up_ctr_next = w_ctr[w_up_idx] - 2'b01;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic             r_valid;
      logic [TAG_W-1:0] r_tag;
      logic [31:0]      r_target;
      logic [1:0]       r_ctr;
      logic             w_sel;

      assign w_sel = upd_valid && (w_up_idx == IDX_W'(gi));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_valid  <= 1'b0;
          r_tag    <= '0;
          r_target <= 32'h0;
          r_ctr    <= ALLOC_CTR;
        end else if (flush) begin
          r_valid <= 1'b0;
        end else if (w_sel) begin
          if (w_up_hit) begin
            r_ctr <= w_up_ctr_next;
            if (upd_taken) r_target <= upd_target;
          end else if (upd_taken) begin
            // Only taken branches allocate; not-taken misses leave the entry alone.
            r_valid  <= 1'b1;
            r_tag    <= w_up_tag;
            r_target <= upd_target;
            r_ctr    <= ALLOC_CTR;
          end
        end
      end

      assign w_valid[gi]  = r_valid;
      assign w_tag[gi]    = r_tag;
      assign w_target[gi] = r_target;
      assign w_ctr[gi]    = r_ctr;
    end
  endgenerate

`ifdef BTB_PERF_EN
  logic [31:0] r_perf_lookups;
  logic [31:0] r_perf_hits;
  logic [31:0] r_perf_mispred;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_lookups <= 32'h0;
      r_perf_hits    <= 32'h0;
      r_perf_mispred <= 32'h0;
    end else begin
      r_perf_lookups <= r_perf_lookups + {31'h0, lookup_en};
      r_perf_hits    <= r_perf_hits + {31'h0, lookup_en && btb_hit};
      r_perf_mispred <= r_perf_mispred + {31'h0, upd_valid && upd_mispredict};
    end
  end

  assign perf_lookups = r_perf_lookups;
  assign perf_hits    = r_perf_hits;
  assign perf_mispred = r_perf_mispred;
  assign w_unused     = ^{lookup_pc[1:0], upd_pc[1:0]};
`else
  assign perf_lookups = 32'h0;
  assign perf_hits    = 32'h0;
  assign perf_mispred = 32'h0;
  assign w_unused     = ^{lookup_pc[1:0], upd_pc[1:0], lookup_en, upd_mispredict};
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios plus randomized traffic
// against a table-of-entries reference model.
module tb_branch_target_buffer;
  localparam int ENTRIES = 64;
  localparam int IDX_W   = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        lookup_en;
  logic        btb_hit;
  logic [31:0] btb_pc;
  logic        predict_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_mispredict;
  logic        flush;
  logic [31:0] perf_lookups;
  logic [31:0] perf_hits;
  logic [31:0] perf_mispred;

  int n_cmp = 0;
  int n_bad = 0;

  branch_target_buffer #(.ENTRIES(ENTRIES), .ALLOC_CTR(2'b10)) dut (
    .clk(clk), .rst(rst),
    .lookup_pc(lookup_pc), .lookup_en(lookup_en),
    .btb_hit(btb_hit), .btb_pc(btb_pc), .predict_taken(predict_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict), .flush(flush),
    .perf_lookups(perf_lookups), .perf_hits(perf_hits), .perf_mispred(perf_mispred)
  );

  always #5 clk = ~clk;

  // Reference model: one record per table slot plus expected perf totals.
  bit          m_valid  [ENTRIES];
  logic [31:0] m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  logic [31:0] m_lookups, m_hits, m_mispred;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] pc);
    return pc / (ENTRIES * 4);
  endfunction

  function automatic logic m_hit(logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic logic [31:0] m_pc(logic [31:0] pc);
    return m_hit(pc) ? m_target[idx_of(pc)] : 32'h0;
  endfunction

  function automatic logic m_pred(logic [31:0] pc);
    return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 2;
    end
    m_lookups = 0; m_hits = 0; m_mispred = 0;
  endfunction

  // Apply what one rising edge does, using the inputs currently driven.
  function automatic void model_edge();
    int i;
    if (lookup_en) m_lookups = m_lookups + 1;
    if (lookup_en && m_hit(lookup_pc)) m_hits = m_hits + 1;
    if (upd_valid && upd_mispredict) m_mispred = m_mispred + 1;
    i = idx_of(upd_pc);
    if (flush) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
    end else if (upd_valid) begin
      if (m_hit(upd_pc)) begin
        m_ctr[i] = upd_taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
        if (upd_taken) m_target[i] = upd_target;
      end else if (upd_taken) begin
        m_valid[i] = 1; m_tag[i] = tag_of(upd_pc); m_target[i] = upd_target; m_ctr[i] = 2;
      end
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input logic mis);
    upd_valid = v; upd_pc = pc; upd_target = tgt; upd_taken = tk; upd_mispredict = mis;
  endtask

  task automatic test_reset();
    rst = 1'b0; lookup_pc = 32'h0001_0000; lookup_en = 0; flush = 0;
    set_upd(0, 0, 0, 0, 0);
    #1;
    $display("reset: lookup %h hit=%b pc=%h pred=%b", lookup_pc, btb_hit, btb_pc, predict_taken);
    n_cmp++; if (btb_hit !== 1'b0) begin n_bad++; $display("FAIL reset_hit got %b want 0", btb_hit); end
    n_cmp++; if (btb_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc got %h want 0", btb_pc); end
    n_cmp++; if (predict_taken !== 1'b0) begin n_bad++; $display("FAIL reset_pred got %b want 0", predict_taken); end
    n_cmp++; if ({perf_lookups, perf_hits, perf_mispred} !== 96'h0) begin
      n_bad++; $display("FAIL reset_perf got %h/%h/%h want 0", perf_lookups, perf_hits, perf_mispred); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_clear();
    @(posedge clk); #1;
  endtask

  task automatic test_train();
    bit exp_pred [7] = '{0, 0, 0, 1, 1, 1, 1};
    bit taken_seq [7] = '{0, 0, 1, 1, 1, 1, 0};
    set_upd(1, 32'h0001_0010, 32'h0001_0040, 1, 0);
    tick();
    set_upd(0, 0, 0, 0, 0);
    lookup_pc = 32'h0001_0010; #1;
    $display("train alloc: hit=%b pc=%h pred=%b", btb_hit, btb_pc, predict_taken);
    n_cmp++; if (btb_hit !== 1'b1) begin n_bad++; $display("FAIL alloc_hit got %b want 1", btb_hit); end
    n_cmp++; if (btb_pc !== 32'h0001_0040) begin n_bad++; $display("FAIL alloc_pc got %h want 00010040", btb_pc); end
    n_cmp++; if (predict_taken !== 1'b1) begin n_bad++; $display("FAIL alloc_pred got %b want 1", predict_taken); end
    for (int i = 0; i < 7; i++) begin
      set_upd(1, 32'h0001_0010, 32'h0001_0040, taken_seq[i], 0);
      tick();
      set_upd(0, 0, 0, 0, 0);
      #1;
      $display("train step %0d taken=%b: hit=%b pc=%h pred=%b", i, taken_seq[i], btb_hit, btb_pc, predict_taken);
      n_cmp++; if (btb_hit !== 1'b1) begin n_bad++; $display("FAIL train_hit[%0d] got %b want 1", i, btb_hit); end
      n_cmp++; if (predict_taken !== exp_pred[i]) begin
        n_bad++; $display("FAIL train_pred[%0d] got %b want %b", i, predict_taken, exp_pred[i]); end
    end
  endtask

  task automatic test_alias();
    set_upd(1, 32'h0001_0110, 32'h0001_0200, 1, 0);
    tick();
    set_upd(0, 0, 0, 0, 0);
    lookup_pc = 32'h0001_0010; #1;
    $display("alias old tag: hit=%b pc=%h", btb_hit, btb_pc);
    n_cmp++; if (btb_hit !== 1'b0) begin n_bad++; $display("FAIL alias_old_hit got %b want 0", btb_hit); end
    n_cmp++; if (btb_pc !== 32'h0) begin n_bad++; $display("FAIL alias_old_pc got %h want 0", btb_pc); end
    lookup_pc = 32'h0001_0110; #1;
    $display("alias new tag: hit=%b pc=%h pred=%b", btb_hit, btb_pc, predict_taken);
    n_cmp++; if (btb_hit !== 1'b1) begin n_bad++; $display("FAIL alias_new_hit got %b want 1", btb_hit); end
    n_cmp++; if (btb_pc !== 32'h0001_0200) begin n_bad++; $display("FAIL alias_new_pc got %h want 00010200", btb_pc); end
    set_upd(1, 32'h0001_0030, 32'h0001_0300, 0, 0);
    tick();
    set_upd(0, 0, 0, 0, 0);
    lookup_pc = 32'h0001_0030; #1;
    $display("not-taken on empty index: hit=%b", btb_hit);
    n_cmp++; if (btb_hit !== 1'b0) begin n_bad++; $display("FAIL nt_alloc_hit got %b want 0", btb_hit); end
  endtask

  task automatic test_same_cycle();
    lookup_pc = 32'h0001_0020;
    set_upd(1, 32'h0001_0020, 32'h0001_2340, 1, 0);
    #1;
    $display("same-cycle lookup+upd: hit=%b", btb_hit);
    n_cmp++; if (btb_hit !== 1'b0) begin n_bad++; $display("FAIL same_cycle_hit got %b want 0", btb_hit); end
    tick();
    set_upd(0, 0, 0, 0, 0);
    #1;
    $display("next cycle: hit=%b pc=%h", btb_hit, btb_pc);
    n_cmp++; if (btb_hit !== 1'b1) begin n_bad++; $display("FAIL next_cycle_hit got %b want 1", btb_hit); end
    n_cmp++; if (btb_pc !== 32'h0001_2340) begin n_bad++; $display("FAIL next_cycle_pc got %h want 00012340", btb_pc); end
  endtask

  task automatic test_flush();
    logic [31:0] pcs [3] = '{32'h0001_0110, 32'h0001_0020, 32'h0001_0050};
    flush = 1;
    set_upd(1, 32'h0001_0050, 32'h0000_0999, 1, 0);
    tick();
    flush = 0;
    set_upd(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      lookup_pc = pcs[i]; #1;
      $display("after flush lookup %h: hit=%b", lookup_pc, btb_hit);
      n_cmp++; if (btb_hit !== 1'b0) begin n_bad++; $display("FAIL flush_hit[%0d] got %b want 0", i, btb_hit); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      lookup_pc = ((32'h100 + 32'($urandom_range(0, 2))) << (IDX_W + 2)) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      lookup_en = 1'($urandom_range(0, 1));
      set_upd(1'($urandom_range(0, 9) < 6),
              ((32'h100 + 32'($urandom_range(0, 2))) << (IDX_W + 2)) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)),
              $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      flush = ($urandom_range(0, 49) == 0);
      #1;
      $display("rand %0d: lk=%h hit=%b pc=%h pred=%b | upd v=%b pc=%h tk=%b fl=%b",
               n, lookup_pc, btb_hit, btb_pc, predict_taken, upd_valid, upd_pc, upd_taken, flush);
      n_cmp++; if (btb_hit !== m_hit(lookup_pc)) begin
        n_bad++; $display("FAIL rand_hit[%0d] got %b want %b", n, btb_hit, m_hit(lookup_pc)); end
      n_cmp++; if (btb_pc !== m_pc(lookup_pc)) begin
        n_bad++; $display("FAIL rand_pc[%0d] got %h want %h", n, btb_pc, m_pc(lookup_pc)); end
      n_cmp++; if (predict_taken !== m_pred(lookup_pc)) begin
        n_bad++; $display("FAIL rand_pred[%0d] got %b want %b", n, predict_taken, m_pred(lookup_pc)); end
`ifdef BTB_PERF_EN
      n_cmp++; if ({perf_lookups, perf_hits, perf_mispred} !== {m_lookups, m_hits, m_mispred}) begin
        n_bad++; $display("FAIL rand_perf[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", n,
                          perf_lookups, perf_hits, perf_mispred, m_lookups, m_hits, m_mispred); end
`endif
      tick();
    end
    lookup_en = 0; flush = 0;
    set_upd(0, 0, 0, 0, 0);
  endtask

  task automatic test_perf();
    logic [31:0] lk [10] = '{32'h0001_0010, 32'h0002_0010, 32'h0001_0020, 32'h0002_0020, 32'h0001_0030,
                             32'h0003_0000, 32'h0003_0004, 32'h0004_0008, 32'h0005_000C, 32'h0006_0000};
    logic [31:0] exp_l, exp_h, exp_m;
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1;
    model_clear();
    set_upd(1, 32'h0001_0010, 32'h0001_0040, 1, 1); tick();
    set_upd(1, 32'h0001_0020, 32'h0001_0080, 1, 1); tick();
    set_upd(1, 32'h0001_0030, 32'h0001_00C0, 1, 0); tick();
    set_upd(0, 0, 0, 0, 0);
    lookup_en = 1;
    for (int i = 0; i < 10; i++) begin
      lookup_pc = lk[i];
      tick();
    end
    lookup_en = 0; #1;
`ifdef BTB_PERF_EN
    exp_l = 10; exp_h = 3; exp_m = 2;
`else
    exp_l = 0; exp_h = 0; exp_m = 0;
`endif
    $display("perf: lookups=%0d hits=%0d mispred=%0d", perf_lookups, perf_hits, perf_mispred);
    n_cmp++; if (perf_lookups !== exp_l) begin n_bad++; $display("FAIL perf_lookups got %0d want %0d", perf_lookups, exp_l); end
    n_cmp++; if (perf_hits !== exp_h) begin n_bad++; $display("FAIL perf_hits got %0d want %0d", perf_hits, exp_h); end
    n_cmp++; if (perf_mispred !== exp_m) begin n_bad++; $display("FAIL perf_mispred got %0d want %0d", perf_mispred, exp_m); end
  endtask

  task automatic test_reset_mid();
    lookup_pc = 32'h0001_0010;
    set_upd(1, 32'h0001_0130, 32'h0001_0500, 1, 1);
    #1;
    n_cmp++; if (btb_hit !== 1'b1) begin n_bad++; $display("FAIL pre_rst_hit got %b want 1", btb_hit); end
    @(posedge clk); #3;
    rst = 0; #1;
    $display("mid-training reset: hit=%b pc=%h pred=%b perf=%0d/%0d/%0d",
             btb_hit, btb_pc, predict_taken, perf_lookups, perf_hits, perf_mispred);
    n_cmp++; if (btb_hit !== 1'b0) begin n_bad++; $display("FAIL mid_rst_hit got %b want 0", btb_hit); end
    n_cmp++; if (btb_pc !== 32'h0) begin n_bad++; $display("FAIL mid_rst_pc got %h want 0", btb_pc); end
    n_cmp++; if (predict_taken !== 1'b0) begin n_bad++; $display("FAIL mid_rst_pred got %b want 0", predict_taken); end
    n_cmp++; if ({perf_lookups, perf_hits, perf_mispred} !== 96'h0) begin
      n_bad++; $display("FAIL mid_rst_perf got %0d/%0d/%0d want 0", perf_lookups, perf_hits, perf_mispred); end
    @(negedge clk);
    set_upd(0, 0, 0, 0, 0);
    rst = 1;
    model_clear();
    lookup_pc = 32'h0001_0130; #1;
    n_cmp++; if (btb_hit !== 1'b0) begin n_bad++; $display("FAIL post_rst_hit got %b want 0", btb_hit); end
  endtask

  initial begin
    test_reset();
    test_train();
    test_alias();
    test_same_cycle();
    test_flush();
    test_random();
    test_perf();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
